// File: rtl/lsu_dtcm_master.sv
// Load/store initiator for a word-organised data TCM with low-lane byte enables.
// Optional LSU_MISALIGN_EN splits word-crossing accesses into two word operations.
module lsu_dtcm_master #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_type,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] WADDR,
  output logic [DW-1:0] WDATA,
  output logic          WEN,
  output logic [2:0]    RW_type,
  output logic [AW-1:0] RADDR,
  output logic          REN,
  input  logic [DW-1:0] RDATA
);

`ifdef LSU_MISALIGN_EN
  typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, RESP} state_t;
  localparam int unsigned XW = 2 * DW;
`else
  typedef enum logic [2:0] {IDLE, RD0, WR0, RESP} state_t;
  localparam int unsigned XW = DW;
`endif

  state_t        state;
  logic          we_q;
  logic [2:0]    type_q;
  logic [1:0]    off_q;
  logic [AW-1:0] idx_q;
  logic [DW-1:0] wdata_q;
`ifdef LSU_MISALIGN_EN
  logic          mis_q;
  logic [DW-1:0] rlo_q;
`endif

  // Upper address bits alias onto the TCM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  logic [1:0] req_off;
  logic       req_ill;
  logic       req_mis;
  assign req_off = req_addr[1:0];
  assign req_ill = (req_type == 3'b011) || (req_type[2] && req_type[1]) || (req_we && req_type[2]);
  assign req_mis = ((req_type[1:0] == 2'b01) && (req_off == 2'b11)) ||
                   ((req_type[1:0] == 2'b10) && (req_off != 2'b00));

  logic [DW-1:0] lane_mask;
  logic [4:0]    sh;
  logic [XW-1:0] src_x;
  logic [XW-1:0] data_x;
  logic [XW-1:0] mask_x;
  logic [XW-1:0] merged_x;
  logic [DW-1:0] ld_raw;
  logic [DW-1:0] ld_ext;

  // Merge store bytes into the read word(s) and extract/extend load data.
  always_comb begin
    case (type_q[1:0])
      2'b00:   lane_mask = {{(DW-8){1'b0}}, 8'hFF};
      2'b01:   lane_mask = {{(DW-16){1'b0}}, 16'hFFFF};
      default: lane_mask = {DW{1'b1}};
    endcase
    sh = {off_q, 3'b000};
`ifdef LSU_MISALIGN_EN
    src_x = (state == RD1) ? {RDATA, rlo_q} : {{DW{1'b0}}, RDATA};
`else
    src_x = RDATA;
`endif
    data_x   = XW'(wdata_q & lane_mask) << sh;
    mask_x   = XW'(lane_mask) << sh;
    merged_x = (src_x & ~mask_x) | data_x;
    ld_raw   = DW'(src_x >> sh);
    ld_ext   = ld_raw;
    case (type_q)
      3'b000:  ld_ext = {{(DW-8){ld_raw[7]}}, ld_raw[7:0]};
      3'b001:  ld_ext = {{(DW-16){ld_raw[15]}}, ld_raw[15:0]};
      3'b100:  ld_ext = {{(DW-8){1'b0}}, ld_raw[7:0]};
      3'b101:  ld_ext = {{(DW-16){1'b0}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      WEN        <= 1'b0;
      REN        <= 1'b0;
      RW_type    <= 3'b000;
      WADDR      <= '0;
      RADDR      <= '0;
      WDATA      <= '0;
      we_q       <= 1'b0;
      type_q     <= 3'b000;
      off_q      <= 2'b00;
      idx_q      <= '0;
      wdata_q    <= '0;
`ifdef LSU_MISALIGN_EN
      mis_q      <= 1'b0;
      rlo_q      <= '0;
`endif
    end else begin
      WEN        <= 1'b0;
      REN        <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            type_q    <= req_type;
            off_q     <= req_off;
            idx_q     <= req_addr[AW+1:2];
            wdata_q   <= req_wdata;
`ifdef LSU_MISALIGN_EN
            mis_q     <= req_mis && !req_ill;
`endif
            if (req_ill) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_mis) begin
`ifdef LSU_MISALIGN_EN
              state <= RD0;
              REN   <= 1'b1;
              RADDR <= req_addr[AW+1:2];
`else
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
`endif
            end else if (!req_we || (req_off != 2'b00)) begin
              state <= RD0;
              REN   <= 1'b1;
              RADDR <= req_addr[AW+1:2];
            end else begin
              state   <= WR0;
              WEN     <= 1'b1;
              WADDR   <= req_addr[AW+1:2];
              WDATA   <= req_wdata;
              RW_type <= {1'b0, req_type[1:0]};
            end
          end
        end
        RD0: begin
`ifdef LSU_MISALIGN_EN
          rlo_q <= RDATA;
`endif
          if (!we_q) begin
`ifdef LSU_MISALIGN_EN
            if (mis_q) begin
              state <= RD1;
              REN   <= 1'b1;
              RADDR <= idx_q + AW'(1);
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= ld_ext;
            end
`else
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_ext;
`endif
          end else begin
            state   <= WR0;
            WEN     <= 1'b1;
            WADDR   <= idx_q;
            WDATA   <= merged_x[DW-1:0];
            RW_type <= 3'b010;
          end
        end
        WR0: begin
`ifdef LSU_MISALIGN_EN
          if (mis_q) begin
            state <= RD1;
            REN   <= 1'b1;
            RADDR <= idx_q + AW'(1);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
`else
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
`endif
        end
`ifdef LSU_MISALIGN_EN
        RD1: begin
          if (!we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_ext;
          end else begin
            state   <= WR1;
            WEN     <= 1'b1;
            WADDR   <= idx_q + AW'(1);
            WDATA   <= merged_x[XW-1:DW];
            RW_type <= 3'b010;
          end
        end
        WR1: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
`endif
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dtcm_master.sv
// Scoreboard bench for lsu_dtcm_master against a behavioural 16-word TCM.
module tb_lsu_dtcm_master;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_type = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          wen;
  logic [2:0]    rw_type;
  logic [AW-1:0] raddr;
  logic          ren;
  wire  [31:0]   rdata;

  always #5 clk = ~clk;

  lsu_dtcm_master #(.AW(AW), .DW(32)) dut (
    .CLK(clk), .RSTN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .WADDR(waddr), .WDATA(wdata), .WEN(wen), .RW_type(rw_type),
    .RADDR(raddr), .REN(ren), .RDATA(rdata)
  );

  // TCM model with a preload port for the bench.
  logic [31:0]   mem [16];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_idx = '0;
  logic [31:0]   pre_val = 32'h0;

  assign rdata = ren ? mem[raddr] : 32'hz;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (wen) begin
      case (rw_type)
        3'b000:  mem[waddr][7:0]  <= wdata[7:0];
        3'b001:  mem[waddr][15:0] <= wdata[15:0];
        default: mem[waddr]       <= wdata;
      endcase
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  int          resp_seen = 0;
  logic [AW-1:0] lw_addr = '0;
  logic [31:0]   lw_data = 32'h0;
  logic [2:0]    lw_type = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: TCM activity bookkeeping and response scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ren === 1'b1 && wen === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL ren_wen_overlap: got REN=1 WEN=1 expected at most one");
      end
      if (wen === 1'b1) begin
        wen_cnt++;
        lw_addr = waddr;
        lw_data = wdata;
        lw_type = rw_type;
      end
      if (ren === 1'b1) ren_cnt++;
      if (resp_valid === 1'b1) begin
        resp_seen++;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none (rdata %h)", resp_rdata);
        end else begin
          mon_e = sbq.pop_front();
          chk({mon_e.name, "_rdata"}, resp_rdata, mon_e.rdata);
          chk({mon_e.name, "_err"}, 32'(resp_err), 32'(mon_e.err));
          chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = AW'(idx);
    pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ee,
                       input int lat, input bit push, input string nm);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = t;
    req_addr  = a;
    req_wdata = d;
    ren_cnt   = 0;
    wen_cnt   = 0;
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc + lat;
      e.name  = nm;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_type  = 3'b010;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(input string nm);
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      chk({nm, "_resp_timeout"}, 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_op(input logic we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] er, input logic ee,
                       input int lat, input string nm);
    issue(we, t, a, d, er, ee, lat, 1'b1, nm);
    wait_done(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] snap;
  int          w6;

  initial begin
    // Reset with a request held present.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) preload(i, 32'h0);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_rw_type", 32'(rw_type), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_wdata", wdata, 32'h0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    ren_cnt = 0;
    wen_cnt = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_no_en", 32'(ren_cnt + wen_cnt), 32'd0);

    // Aligned word store then load.
    do_op(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, "sw8");
    chk("sw8_wen_cnt", 32'(wen_cnt), 32'd1);
    chk("sw8_ren_cnt", 32'(ren_cnt), 32'd0);
    chk("sw8_waddr", 32'(lw_addr), 32'd2);
    chk("sw8_rw_type", 32'(lw_type), 32'b010);
    chk("sw8_wdata", lw_data, 32'hDEAD_BEEF);
    do_op(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "lw8");
    chk("lw8_ren_cnt", 32'(ren_cnt), 32'd1);

    // Byte RMW store and signed/unsigned byte loads.
    preload(2, 32'h1122_3344);
    do_op(1'b1, 3'b000, 32'h9, 32'h1234_56A5, 32'h0, 1'b0, 3, "sb9");
    chk("sb9_ren_cnt", 32'(ren_cnt), 32'd1);
    chk("sb9_wen_cnt", 32'(wen_cnt), 32'd1);
    chk("sb9_wdata", lw_data, 32'h1122_A544);
    chk("sb9_rw_type", 32'(lw_type), 32'b010);
    chk("sb9_waddr", 32'(lw_addr), 32'd2);
    do_op(1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFF_FFA5, 1'b0, 2, "lb9");
    do_op(1'b0, 3'b100, 32'h9, 32'h0, 32'h0000_00A5, 1'b0, 2, "lbu9");

    // Direct half store and half loads.
    do_op(1'b1, 3'b001, 32'h4, 32'h0000_8001, 32'h0, 1'b0, 2, "sh4");
    chk("sh4_ren_cnt", 32'(ren_cnt), 32'd0);
    chk("sh4_rw_type", 32'(lw_type), 32'b001);
    chk("sh4_waddr", 32'(lw_addr), 32'd1);
    do_op(1'b0, 3'b001, 32'h4, 32'h0, 32'hFFFF_8001, 1'b0, 2, "lh4");
    do_op(1'b0, 3'b101, 32'h4, 32'h0, 32'h0000_8001, 1'b0, 2, "lhu4");

    // Half RMW at offset 2, top-byte load, aliasing and direct byte store.
    preload(3, 32'hAABB_CCDD);
    do_op(1'b1, 3'b001, 32'hE, 32'h0000_7FFE, 32'h0, 1'b0, 3, "sh_e");
    chk("sh_e_mem", mem[3], 32'h7FFE_CCDD);
    do_op(1'b0, 3'b001, 32'hE, 32'h0, 32'h0000_7FFE, 1'b0, 2, "lh_e");
    do_op(1'b0, 3'b000, 32'hF, 32'h0, 32'h0000_007F, 1'b0, 2, "lb_f");
    do_op(1'b0, 3'b010, 32'h1000_000C, 32'h0, 32'h7FFE_CCDD, 1'b0, 2, "lw_alias");
    do_op(1'b1, 3'b000, 32'hC, 32'hFFFF_FF11, 32'h0, 1'b0, 2, "sb_c");
    chk("sb_c_rw_type", 32'(lw_type), 32'b000);
    chk("sb_c_mem", mem[3], 32'h7FFE_CC11);

    // Illegal types: no TCM access.
    do_op(1'b1, 3'b100, 32'h0, 32'h0000_00FF, 32'h0, 1'b1, 1, "sbu_ill");
    chk("sbu_ill_en", 32'(ren_cnt + wen_cnt), 32'd0);
    do_op(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, "t011_ill");
    do_op(1'b0, 3'b110, 32'h4, 32'h0, 32'h0, 1'b1, 1, "t110_ill");
    chk("t110_ill_en", 32'(ren_cnt + wen_cnt), 32'd0);

    // Misaligned accesses.
    preload(1, 32'h1122_3344);
    preload(2, 32'h5566_7788);
    preload(15, 32'h0102_0304);
    preload(0, 32'h0A0B_0C0D);
`ifdef LSU_MISALIGN_EN
    do_op(1'b0, 3'b010, 32'h6, 32'h0, 32'h7788_1122, 1'b0, 3, "lw6_mis");
    chk("lw6_mis_ren_cnt", 32'(ren_cnt), 32'd2);
    do_op(1'b0, 3'b001, 32'h7, 32'h0, 32'hFFFF_8811, 1'b0, 3, "lh7_mis");
    do_op(1'b0, 3'b010, 32'h3E, 32'h0, 32'h0C0D_0102, 1'b0, 3, "lw_wrap");
    do_op(1'b1, 3'b010, 32'h6, 32'hCAFE_BABE, 32'h0, 1'b0, 5, "sw6_mis");
    chk("sw6_mis_wen_cnt", 32'(wen_cnt), 32'd2);
    chk("sw6_mis_mem1", mem[1], 32'hBABE_3344);
    chk("sw6_mis_mem2", mem[2], 32'h5566_CAFE);
`else
    do_op(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1, "lw6_mis");
    chk("lw6_mis_ren_cnt", 32'(ren_cnt), 32'd0);
    do_op(1'b0, 3'b001, 32'h7, 32'h0, 32'h0, 1'b1, 1, "lh7_mis");
    do_op(1'b1, 3'b010, 32'h6, 32'hCAFE_BABE, 32'h0, 1'b1, 1, "sw6_mis");
    chk("sw6_mis_en", 32'(ren_cnt + wen_cnt), 32'd0);
    chk("sw6_mis_mem1", mem[1], 32'h1122_3344);
`endif

    // Reset during WR0 of an RMW byte store.
    preload(4, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h11, 32'h0000_005A, 32'h0, 1'b0, 3, 1'b0, "sb_rst");
    w6 = 0;
    while (wen !== 1'b1 && w6 < 10) begin
      @(negedge clk);
      w6++;
    end
    chk("sb_rst_reached_wr0", 32'(wen), 32'd1);
    snap = 32'(resp_seen);
    rst_n = 1'b0;
    #1;
    chk("sb_rst_wen_drop", 32'(wen), 32'd0);
    chk("sb_rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("sb_rst_no_resp", 32'(resp_seen) - snap, 32'd0);
    chk("sb_rst_word_intact", 32'((mem[4] === 32'h1122_3344) || (mem[4] === 32'h1122_5A44)), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_dtcm_master.md
Name: lsu_dtcm_master

Overview:
- Load/store initiator that drives the word-organised data TCM from the core's memory stage.
- Accepts one byte/half/word load or store request at a time.
- Translates byte addresses to word indices; performs read-modify-write where the TCM's fixed low-lane byte enables cannot express the store.
- Extracts and sign- or zero-extends load data; returns one response per request.

Parameters:
AW, 4, TCM word-index width; TCM depth is 2^AW words
DW, 32, data width; fixed at 32

Ports:
CLK  in  1  single clock
RSTN  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted on req_valid&&req_ready
req_we  in  1  1=store, 0=load
req_type  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads only for BU/HU)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  misaligned or illegal type; valid with resp_valid
WADDR  out  AW  TCM write word index
WDATA  out  32  TCM write data
WEN  out  1  TCM write enable
RW_type  out  3  TCM lane select: 000 lane0, 001 lanes1:0, 010 all lanes
RADDR  out  AW  TCM read word index
REN  out  1  TCM read enable
RDATA  in  32  TCM combinational read data; high-Z when REN=0

Behaviour:
- Word index: addr[AW+1:2]; higher address bits are ignored, so accesses alias. Offset: addr[1:0].
- Request capture: addr, type, wdata and we are registered on acceptance; the request inputs are ignored at all other times.
- States: IDLE, RD0, WR0, RD1, WR1, RESP.
- Loads: IDLE->RD0. In RD0, REN=1 and RADDR=index. RDATA is captured at the edge ending RD0. Then RESP.
- Load latency: resp_valid is high in the 2nd cycle after the accept edge.
- Load data extraction: byte lane = offset; half = bytes offset+1:offset. B/H are sign-extended; BU/HU are zero-extended.
- Direct store: applies when offset==0, or type W at offset 0. IDLE->WR0.
  - WEN=1, RW_type = 000/001/010 for B/H/W, WDATA = req_wdata.
  - Then RESP. resp_valid is high 2 cycles after acceptance.
- RMW store: applies to B/H with offset!=0. IDLE->RD0->WR0->RESP.
  - RD0 reads the word.
  - WR0 writes the merged word (new bytes placed at offset) with RW_type=010.
  - resp_valid is high 3 cycles after acceptance.
- Illegal type: store with type BU/HU, or type 011/11x. Goes IDLE->RESP with resp_err=1 and no TCM access.
- Misaligned access (H at offset 3; W at offset!=0): handled per LSU_MISALIGN_EN.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure. req_ready=0 in RESP, so back-to-back requests are spaced at least one cycle apart.
- Output decode: WEN, REN, RADDR, WADDR, WDATA and RW_type are decoded from state and registers only, never from request inputs. REN and WEN are never both 1.
- RDATA sampling: RDATA is sampled only in cycles with REN=1.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, WEN=0, REN=0, RW_type=000, WADDR=0, RADDR=0, WDATA=0, state=IDLE.
- Reset mid-operation: reset forces IDLE immediately and drops WEN asynchronously. A partially completed RMW leaves the word either unmodified or fully written, never torn within a word. No response is issued.

Optional Feature:
LSU_MISALIGN_EN
- Defined:
  - Misaligned loads: RD0 reads word i, RD1 reads word (i+1) mod 2^AW; the bytes are concatenated and extended. Load latency is 3 cycles.
  - Misaligned stores: RD0->WR0->RD1->WR1, each word read-merged-written with RW_type=010. Store latency is 5 cycles.
  - resp_err=0 for misaligned accesses.
- Undefined:
  - RD1/WR1 are absent.
  - Misaligned requests go IDLE->RESP with resp_err=1, resp_rdata=0 and no REN/WEN.

Test Plan:
1. Reset with req_valid=1 asserted: outputs hold the reset values; after RSTN rises, req_ready=1 and no TCM enables until acceptance.
2. SW 0xDEADBEEF @0x8, then LW @0x8 -> one WEN cycle, WADDR=2, RW_type=010; resp_rdata=0xDEADBEEF two cycles after the load is accepted.
3. SB 0xA5 @0x9 over word 0x11223344 -> RD0 then WR0 with WDATA=0x1122A544, RW_type=010; LB @0x9 -> 0xFFFFFFA5; LBU @0x9 -> 0x000000A5.
4. SH 0x8001 @0x4 -> direct WR0, RW_type=001, no REN; LH @0x4 -> 0xFFFF8001; LHU @0x4 -> 0x00008001.
5. LW @0x6 -> without the macro: resp_err=1 and REN never asserted; with LSU_MISALIGN_EN and words[1]=0x11223344, words[2]=0x55667788: resp_rdata=0x77881122 after 3 cycles.
6. Assert RSTN=0 during WR0 of an RMW SB -> WEN drops the same cycle; the word reads back either the old or the fully merged value; no resp_valid pulse.
